// File: rtl/mem_burst_master_if.sv
// Client command/data handshake plus the RAM pin bundle driven by mem_burst_master.
interface mem_burst_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_wr;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_len;
    logic [7:0] wdata;
    logic       wdata_valid;
    logic       wdata_ready;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       busy;
    logic       done;
    logic [7:0] mem_address;
    logic [7:0] mem_data;
    logic       mem_wr;
    logic       mem_cs;
    logic [7:0] mem_o;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wdata, wdata_valid, mem_o,
        output cmd_ready, wdata_ready, rdata, rdata_valid, busy, done,
               mem_address, mem_data, mem_wr, mem_cs
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_len, wdata, wdata_valid, mem_o,
        input  cmd_ready, wdata_ready, rdata, rdata_valid, busy, done,
               mem_address, mem_data, mem_wr, mem_cs
    );
endinterface

// File: rtl/mem_burst_master.sv
// Single-command burst initiator for the 256x8 single-port RAM: one byte access per clock,
// read data registered out, write data streamed in with a valid/ready handshake.
module mem_burst_master (
    input  logic                clock,
    input  logic                reset,
    mem_burst_master_if.master  bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t     state, state_n;
    logic [7:0] addr_q, addr_n;
    logic [7:0] remain_q, remain_n;
    logic [7:0] rdata_q;
    logic       rdata_valid_q;
    logic       beat;

    always_comb begin
        state_n  = state;
        addr_n   = addr_q;
        remain_n = remain_q;
        beat     = 1'b0;
        case (state)
            IDLE: if (bus.cmd_valid) begin
                state_n  = bus.cmd_wr ? WR : RD;
                addr_n   = bus.cmd_addr;
                remain_n = bus.cmd_len;
            end
            RD:      beat = 1'b1;
            WR:      beat = bus.wdata_valid;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // remain_q counts beats still owed after this one; zero means this is the last
        if (beat) begin
            addr_n = addr_q + 8'd1;
            if (remain_q == 8'd0) state_n = DONE;
            else                  remain_n = remain_q - 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            addr_q        <= 8'd0;
            remain_q      <= 8'd0;
            rdata_q       <= 8'd0;
            rdata_valid_q <= 1'b0;
        end else begin
            state         <= state_n;
            addr_q        <= addr_n;
            remain_q      <= remain_n;
            rdata_valid_q <= (state == RD);
            if (state == RD) rdata_q <= bus.mem_o;
        end
    end

    // Bus pins decode straight from state so an async reset frees the RAM immediately
    always_comb begin
        bus.mem_address = addr_q;
        bus.mem_data    = bus.wdata;
        bus.mem_wr      = 1'b0;
        bus.mem_cs      = 1'b1;
        case (state)
            RD: bus.mem_cs = 1'b0;
            WR: begin
                bus.mem_wr = 1'b1;
                bus.mem_cs = ~bus.wdata_valid;
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready   = (state == IDLE);
    assign bus.wdata_ready = (state == WR);
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master: RAM model, read-data scoreboard, done/cs monitors.
module tb_mem_burst_master;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_burst_master_if bus();
    mem_burst_master dut (.clock(clock), .reset(reset), .bus(bus));

    logic [7:0] ram [0:255];
    initial for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    always @(posedge clock) if (!bus.mem_cs && bus.mem_wr) ram[bus.mem_address] <= bus.mem_data;
    assign bus.mem_o = ram[bus.mem_address];

    typedef struct { logic [7:0] data; logic last; } exp_t;
    exp_t q[$];

    int passed = 0, total = 0;
    int cyc = 0, done_cnt = 0, done_cyc = -1, cs_low_cnt = 0;
    logic [7:0] wbuf [0:7];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard monitor: every presented read beat must match the next expected byte
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.done) begin done_cnt++; done_cyc = cyc; end
            if (!bus.mem_cs) cs_low_cnt++;
            if (bus.rdata_valid) begin
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL rdata_unexpected got=%0h expected=none", bus.rdata);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rdata", {24'd0, bus.rdata}, {24'd0, e.data});
                    chk("done_with_last", {31'd0, bus.done}, {31'd0, e.last});
                end
            end
        end
    end

    task automatic push(input logic [7:0] d, input logic last);
        exp_t e;
        e.data = d; e.last = last;
        q.push_back(e);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            if (bus.cmd_ready) return;
        end
        chk("wait_idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] len, output int acc);
        bus.cmd_wr = wr; bus.cmd_addr = a; bus.cmd_len = len; bus.cmd_valid = 1'b1;
        @(posedge clock); #1;
        bus.cmd_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic do_write(input logic [7:0] a, input int len, input int stall_at, input int stall_n);
        int acc, cs0, dc0;
        logic [7:0] ea;
        cs0 = cs_low_cnt; dc0 = done_cnt;
        issue(1'b1, a, 8'(len), acc);
        for (int i = 0; i <= len; i++) begin
            if (i == stall_at) begin
                bus.wdata_valid = 1'b0;
                ea = a + 8'(i);
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clock);
                    chk("stall_cs_high", {31'd0, bus.mem_cs}, 32'd1);
                    chk("stall_addr", {24'd0, bus.mem_address}, {24'd0, ea});
                    @(posedge clock); #1;
                end
            end
            bus.wdata = wbuf[i]; bus.wdata_valid = 1'b1;
            @(posedge clock); #1;
        end
        bus.wdata_valid = 1'b0;
        wait_idle();
        chk("wr_done_cycle", 32'(done_cyc), 32'(acc + len + 1 + stall_n));
        chk("wr_cs_low_cycles", 32'(cs_low_cnt - cs0), 32'(len + 1));
        chk("wr_done_pulses", 32'(done_cnt - dc0), 32'd1);
    endtask

    task automatic do_read(input logic [7:0] a, input int len);
        int acc, dc0;
        dc0 = done_cnt;
        issue(1'b0, a, 8'(len), acc);
        wait_idle();
        chk("rd_done_cycle", 32'(done_cyc), 32'(acc + len + 1));
        chk("rd_done_pulses", 32'(done_cnt - dc0), 32'd1);
    endtask

    initial begin
        int acc, dc0;
        bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_addr = 8'h00; bus.cmd_len = 8'h00;
        bus.wdata = 8'h00; bus.wdata_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_mem_cs", {31'd0, bus.mem_cs}, 32'd1);
        chk("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        chk("rst_rdata", {24'd0, bus.rdata}, 32'd0);
        chk("rst_rdata_valid", {31'd0, bus.rdata_valid}, 32'd0);
        chk("rst_wdata_ready", {31'd0, bus.wdata_ready}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);

        // 4-beat write at 0x10, then read it back
        wbuf[0] = 8'hA0; wbuf[1] = 8'hA1; wbuf[2] = 8'hA2; wbuf[3] = 8'hA3;
        do_write(8'h10, 3, -1, 0);
        chk("ram10", {24'd0, ram[8'h10]}, 32'hA0);
        chk("ram11", {24'd0, ram[8'h11]}, 32'hA1);
        chk("ram12", {24'd0, ram[8'h12]}, 32'hA2);
        chk("ram13", {24'd0, ram[8'h13]}, 32'hA3);
        chk("ram14_untouched", {24'd0, ram[8'h14]}, 32'h00);
        push(8'hA0, 1'b0); push(8'hA1, 1'b0); push(8'hA2, 1'b0); push(8'hA3, 1'b1);
        do_read(8'h10, 3);

        // Wrap-around through 0xFF -> 0x00
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        do_write(8'hFE, 2, -1, 0);
        chk("ramFE", {24'd0, ram[8'hFE]}, 32'h11);
        chk("ramFF", {24'd0, ram[8'hFF]}, 32'h22);
        chk("ram00", {24'd0, ram[8'h00]}, 32'h33);
        push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b1);
        do_read(8'hFE, 2);

        // Write with a 2-cycle wdata_valid gap between beats 1 and 2
        wbuf[0] = 8'h55; wbuf[1] = 8'h66; wbuf[2] = 8'h77; wbuf[3] = 8'h88;
        do_write(8'h40, 3, 2, 2);
        chk("ram40", {24'd0, ram[8'h40]}, 32'h55);
        chk("ram41", {24'd0, ram[8'h41]}, 32'h66);
        chk("ram42", {24'd0, ram[8'h42]}, 32'h77);
        chk("ram43", {24'd0, ram[8'h43]}, 32'h88);

        // 8-beat read aborted by reset after 3 captured beats
        chk("sb_empty_before_abort", 32'(q.size()), 32'd0);
        push(8'hA0, 1'b0); push(8'hA1, 1'b0); push(8'hA2, 1'b0);
        dc0 = done_cnt;
        issue(1'b0, 8'h10, 8'd7, acc);
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1 reset = 1'b1;
        #1;
        chk("abort_mem_cs", {31'd0, bus.mem_cs}, 32'd1);
        chk("abort_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("abort_rdata_valid", {31'd0, bus.rdata_valid}, 32'd0);
        chk("abort_rdata", {24'd0, bus.rdata}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("abort_no_done", 32'(done_cnt - dc0), 32'd0);
        chk("abort_ready_after", {31'd0, bus.cmd_ready}, 32'd1);
        chk("abort_beats_seen", 32'(q.size()), 32'd0);

        push(8'h22, 1'b1);
        do_read(8'hFF, 0);
        repeat (2) @(negedge clock);
        chk("sb_empty_at_end", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_burst_master.md
# mem_burst_master

Bus initiator that drives the team's 256×8 single-port RAM through its `address`/`data`/`wr`/`cs`/`o` pins. It accepts one command at a time: read or write, a start address, and a burst length. It then performs one byte access per clock, streaming read data out or write data in. It sits between client logic (CPU datapath, loaders, test sequencers) and the RAM, and is the only block that drives the RAM bus.

## Interface
Parameters: none. Address width is 8 bits, data width is 8 bits, and memory depth is 256. All are fixed by the RAM.

- `clock`  in  1  sole clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  block can accept a command (high only in IDLE)
- `cmd_wr`  in  1  0 = read burst, 1 = write burst
- `cmd_addr`  in  8  start address
- `cmd_len`  in  8  beats minus one (0 → 1 beat, 8'hFF → 256 beats)
- `wdata`  in  8  write byte
- `wdata_valid`  in  1  `wdata` is valid
- `wdata_ready`  out  1  block consumes `wdata` at this edge when `wdata_valid` is high (high only in WR)
- `rdata`  out  8  registered read byte
- `rdata_valid`  out  1  `rdata` holds a new beat this cycle; there is no backpressure
- `busy`  out  1  high in RD, WR and DONE
- `done`  out  1  one-cycle pulse after the last beat of a burst
- `mem_address`  out  8  to RAM `address`
- `mem_data`  out  8  to RAM `data`
- `mem_wr`  out  1  to RAM `wr` (1 = write)
- `mem_cs`  out  1  to RAM `cs`, active-low
- `mem_o`  in  8  from RAM `o`; combinational read data

## Operation
- States: IDLE, RD, WR, DONE. Registers: `state`, `addr_q[7:0]`, `remain_q[7:0]`, `rdata`, `rdata_valid`.
- IDLE → RD or WR on an edge with `cmd_valid && cmd_ready`.
  - At that edge: `addr_q ← cmd_addr`, `remain_q ← cmd_len`.
  - `cmd_*` is ignored in every other state.
- RD:
  - Bus drive: `mem_cs=0`, `mem_wr=0`, `mem_address=addr_q`.
  - Every edge: `rdata ← mem_o`, `rdata_valid ← 1`, `addr_q ← addr_q+1`.
  - If `remain_q==0`, go to DONE; otherwise `remain_q ← remain_q-1`.
- WR:
  - Bus drive: `mem_wr=1`, `mem_address=addr_q`, `mem_data=wdata`, `mem_cs=~wdata_valid`.
  - On an edge with `wdata_valid`: the RAM captures the byte, `addr_q` increments, and `remain_q` decrements or the block goes to DONE, with the same rule as RD.
  - With `wdata_valid` low: no bus cycle (`mem_cs=1`) and no register change.
- DONE: `done=1` and the bus is idle. The next edge goes to IDLE.
- `rdata_valid` is cleared on any edge where no read beat is captured. `rdata` holds its last value.
- Bus outputs are combinational decodes of `state`/`addr_q` and `wdata`/`wdata_valid` only.
  - Outside RD/WR: `mem_cs=1`, `mem_wr=0`, `mem_address=addr_q`, `mem_data=wdata`.
- Address arithmetic is modulo 256. 8'hFF wraps to 8'h00 mid-burst with no error.
  - A 256-beat burst touches every location exactly once.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State: `state=IDLE`, `addr_q=0`, `remain_q=0`.
  - Outputs: `rdata=0`, `rdata_valid=0`, `done=0`, `busy=0`, `cmd_ready=1`, `wdata_ready=0`, `mem_cs=1`, `mem_wr=0`.
- Reset mid-burst aborts the burst at once: `mem_cs` deasserts without waiting for a clock, and no `done` is produced. Bytes already written stay written.
- Read burst of N=len+1 beats, command accepted at edge E0:
  - Beat k (k=0..N-1) is addressed in the cycle after edge Ek and captured at edge E(k+1).
  - `rdata_valid` is high for the N cycles following E1..EN.
  - `done` is high in the cycle after EN, coincident with the last `rdata_valid`.
  - `cmd_ready` returns after E(N+1).
- Write burst: minimum N cycles in WR, plus one cycle for each `wdata_valid`-low cycle.
  - `done` is high in the cycle after the last accepted edge.
- Command-to-command gap is a minimum of 2 idle edges, covering DONE and IDLE.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle → outputs take their reset values immediately (`mem_cs=1`, `cmd_ready=1`, `rdata=8'h00`, `rdata_valid=0`).
- Write burst: `cmd_wr=1`, `cmd_addr=8'h10`, `cmd_len=3`, `wdata` A0,A1,A2,A3 with `wdata_valid` held high → RAM[0x10..0x13]=A0..A3, exactly 4 `mem_cs`-low cycles, `done` pulses once the cycle after the 4th edge.
- Read-back: `cmd_wr=0`, `cmd_addr=8'h10`, `cmd_len=3` → `rdata` = A0,A1,A2,A3 on 4 consecutive `rdata_valid` cycles, with `done` coincident with A3.
- Wrap-around: write `cmd_addr=8'hFE`, `cmd_len=2`, data 11,22,33 → RAM[FE]=11, RAM[FF]=22, RAM[00]=33; a read of the same range returns 11,22,33.
- Write stall: drop `wdata_valid` for 2 cycles between beats 1 and 2 → `mem_cs=1` and `mem_address` stable during the gap, all beats land at consecutive addresses, and `done` is delayed by exactly 2 cycles.
- Reset mid-read: `cmd_len=7`, assert `reset` after 3 beats → `mem_cs=1` at once, no `done`; after release `cmd_ready=1`, and a new 1-beat read returns the correct byte.
